seg_scan_disp: RTL and testbench
================================

# seg_scan_disp

Six-digit multiplexed seven-segment display driver sitting directly downstream of the RAM read path: it takes a binary value read from RAM, converts it to BCD with a sequential shift-add-3 engine, and time-multiplexes the digits onto the board's `sel`/`seg` pins. It owns all display timing. Upstream logic only presents a value with a one-cycle valid strobe.

## Interface
- `CNT_MAX`, 49_999: per-digit dwell is CNT_MAX+1 clocks (1 ms at 50 MHz).
- `sys_clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `data` in 20: unsigned binary value to display.
- `data_vld` in 1: single-cycle strobe that samples `data`.
- `point` in 6: decimal-point enables, bit i = digit i (digit 0 = rightmost).
- `seg_en` in 1: display enable.
- `busy` out 1: conversion in progress.
- `sel` out 6: digit select, active-low, one-hot-low.
- `seg` out 8: segments, active-low. `seg[7]` = dp, `seg[6:0]` = g..a.

## Operation
- Conversion FSM has three states: IDLE, CONV, LOAD.
- IDLE:
  - On `data_vld`, latch the value, clamped to 999_999 if `data` > 999_999.
  - Clear the 24-bit BCD accumulator and go to CONV.
- CONV runs 20 iterations, one per clock:
  - Add 3 to each BCD nibble that is ≥5.
  - Then shift {bcd, bin} left by 1.
  - After the 20th iteration, go to LOAD.
- LOAD: copy the accumulator into the 6 displayed digit registers, then return to IDLE.
- `busy` = 1 in CONV and LOAD.
- `data_vld` while `busy` is ignored; there is no queue.
- Scan counter:
  - Counts 0..CNT_MAX and wraps.
  - On the wrap, digit index advances 0→1→…→5→0.
- `sel` = ~(1 << idx).
- `seg` = code(digit[idx]) with `seg[7]` = ~point[idx].
- Codes 0–9 are C0,F9,A4,B0,99,92,82,F8,80,90 (dp bit shown as 1).
- With `seg_en` = 0:
  - `sel` = 6'h3F and `seg` = 8'hFF.
  - The scan counter and conversion keep running.
- Displayed digits change only in LOAD, so there is no tearing mid-scan.

## Timing
- Reset values:
  - `busy` = 0, `sel` = 6'h3F, `seg` = 8'hFF.
  - Digit registers = 0, idx = 0, scan counter = 0, FSM = IDLE.
- Reset mid-conversion aborts it; the digit registers return to 0.
- Latency with `data_vld` high in cycle N:
  - `busy` is high in cycles N+1..N+21 (20 CONV + 1 LOAD).
  - Digit registers update at the end of N+21.
  - `busy` is low in N+22, and a new `data_vld` is accepted in N+22.
- `sel`/`seg` are registered: they change one cycle after the idx/digit change they reflect.
- idx changes in the cycle after the counter reaches CNT_MAX.
- Full scan period is 6·(CNT_MAX+1) clocks.
- `data_vld` and reset in the same cycle: reset wins.

## Configuration
- `SEG_LZ_BLANK_EN` defined: leading-zero blanking.
  - From digit 5 downward, each zero digit above the first non-zero digit outputs `seg` = 8'hFF, including the dp.
  - Digit 0 is never blanked, so value 0 shows "0".
- `SEG_LZ_BLANK_EN` undefined: all six digits always show, zeros included.

## Structure
- Package `seg_pkg`:
  - DIGITS = 6, BCD_W = 24, BIN_W = 20, MAX_VAL = 999_999.
  - The 10 segment code constants and the FSM state enum.
- Sub-module `bin2bcd_seq` holds the IDLE/CONV/LOAD FSM, clamp, accumulator and `busy`.
- Top holds the scan counter, idx, digit registers and segment encode.

## Test plan
Run with CNT_MAX = 9, so dwell is 10 clocks.
- Reset: hold `rst` 3 cycles → `sel` = 3F, `seg` = FF, `busy` = 0. After release with `seg_en` = 1, every digit shows C0.
- Convert: `data` = 123_456 with `data_vld` at cycle N → `busy` high N+1..N+21. Then digit 0..5 show 82,92,99,B0,A4,F9, with `sel` = 3E,3D,3B,37,2F,1F, 10 clocks each.
- Clamp and point: `data` = 1_000_000 → all digits show 90. With `point` = 6'b000100, digit 2 shows 10 and the others show 90.
- Busy ignore: second `data_vld` with 555_555 at N+5 during conversion of 000_042 → display settles to 000_042; `busy` falls at N+22.
- Blanking: `data` = 42 → with `SEG_LZ_BLANK_EN`, digits 5..2 show FF and digits 1,0 show 99,A4. Without it, digits 5..2 show C0.
- Reset mid-conversion: assert `rst` at N+10 → `busy` = 0 next cycle, digits show 0, and a later `data_vld` converts normally. `seg_en` = 0 at any time → `sel` = 3F, `seg` = FF.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants, segment codes and conversion FSM states for the
// six-digit multiplexed seven-segment display driver.
package seg_pkg;

    localparam int DIGITS = 6;
    localparam int BCD_W  = 24;
    localparam int BIN_W  = 20;
    localparam logic [BIN_W-1:0] MAX_VAL = 20'd999_999;

    // Active-low segment patterns, bit 7 (dp) held at 1 (off)
    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } conv_state_t;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter: one iteration per clock,
// input clamped to MAX_VAL, one-cycle load pulse when the result is ready.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic             sys_clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] data,
    input  logic             data_vld,
    output logic             busy,
    output logic             load,
    output logic [BCD_W-1:0] bcd
);

    localparam logic [4:0] LAST_ITER = 5'(BIN_W - 1);

    conv_state_t      state, state_nxt;
    logic [BIN_W-1:0] bin;
    logic [BCD_W-1:0] bcd_adj;
    logic [4:0]       iter;

    always_ff @(posedge sys_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: if (data_vld) state_nxt = CONV;
            CONV: begin
                busy = 1'b1;
                if (iter == LAST_ITER) state_nxt = LOAD;
            end
            LOAD: begin
                busy      = 1'b1;
                load      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Adjusted accumulator and binary shift left together as one register
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            bin  <= '0;
            bcd  <= '0;
            iter <= '0;
        end else if (state == IDLE && data_vld) begin
            bin  <= (data > MAX_VAL) ? MAX_VAL : data;
            bcd  <= '0;
            iter <= '0;
        end else if (state == CONV) begin
            bcd  <= {bcd_adj[BCD_W-2:0], bin[BIN_W-1]};
            bin  <= {bin[BIN_W-2:0], 1'b0};
            iter <= iter + 5'd1;
        end
    end

endmodule

// File: rtl/seg_scan_disp.sv
// Six-digit multiplexed seven-segment driver with sequential BCD conversion.
// Optional leading-zero blanking: define SEG_LZ_BLANK_EN.
module seg_scan_disp
    import seg_pkg::*;
#(
    parameter int CNT_MAX = 49_999
)(
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [19:0] data,
    input  logic        data_vld,
    input  logic [5:0]  point,
    input  logic        seg_en,
    output logic        busy,
    output logic [5:0]  sel,
    output logic [7:0]  seg
);

    localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX);
    localparam logic [2:0]    IDX_LAST = 3'(DIGITS - 1);

    logic [CW-1:0]    scan_cnt;
    logic [2:0]       idx;
    logic [BCD_W-1:0] digit_bcd;
    logic [BCD_W-1:0] conv_bcd;
    logic             conv_load;
    logic [3:0]       cur_digit;
    logic [7:0]       cur_code;
    logic [DIGITS-1:0] blank;

    bin2bcd_seq u_conv (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .data     (data),
        .data_vld (data_vld),
        .busy     (busy),
        .load     (conv_load),
        .bcd      (conv_bcd)
    );

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == CNT_LAST) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Displayed digits only change on the converter's load pulse, never mid-scan
    always_ff @(posedge sys_clk) begin
        if (rst)            digit_bcd <= '0;
        else if (conv_load) digit_bcd <= conv_bcd;
    end

`ifdef SEG_LZ_BLANK_EN
    always_comb begin
        logic lead;
        lead  = 1'b1;
        blank = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead     = lead && (digit_bcd[4*i +: 4] == 4'd0);
            blank[i] = lead;
        end
    end
`else
    assign blank = '0;
`endif

    assign cur_digit = digit_bcd[{idx, 2'b00} +: 4];
    assign cur_code  = seg_code(cur_digit);

    always_ff @(posedge sys_clk) begin
        if (rst || !seg_en) begin
            sel <= 6'h3F;
            seg <= 8'hFF;
        end else begin
            sel <= ~(6'b1 << idx);
            seg <= blank[idx] ? 8'hFF : {~point[idx], cur_code[6:0]};
        end
    end

endmodule

// File: tb/tb_seg_scan_disp.sv
// Directed scoreboard bench for seg_scan_disp with a 10-clock digit dwell;
// expectations follow SEG_LZ_BLANK_EN the same way the design does.
module tb_seg_scan_disp;

    localparam int CNT_MAX = 9;
    localparam int DWELL   = CNT_MAX + 1;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] data = '0;
    logic        data_vld = 1'b0;
    logic [5:0]  point = '0;
    logic        seg_en = 1'b1;
    logic        busy;
    logic [5:0]  sel;
    logic [7:0]  seg;

    typedef struct {
        int         k;
        logic [5:0] sel;
        logic [7:0] seg;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [7:0] code_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    seg_scan_disp #(.CNT_MAX(CNT_MAX)) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .data     (data),
        .data_vld (data_vld),
        .point    (point),
        .seg_en   (seg_en),
        .busy     (busy),
        .sel      (sel),
        .seg      (seg)
    );

    always #5 sys_clk = ~sys_clk;

    // Cycle index since the last reset; 0 is the first cycle with rst low
    always @(posedge sys_clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h (cyc=%0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected display of a value, digit 0 first
    task automatic push_value(input int v, input logic [5:0] pt);
        int   vv;
        int   p;
        int   d;
        exp_t e;
        vv = (v > 999_999) ? 999_999 : v;
        p  = 1;
        for (int k = 0; k < 6; k++) begin
            d     = (vv / p) % 10;
            e.k   = k;
            e.sel = 6'h3F ^ (6'h01 << k);
            e.seg = {~pt[k], code_tab[d][6:0]};
`ifdef SEG_LZ_BLANK_EN
            if (k > 0 && vv < p * 1) e.seg = 8'hFF;
`endif
            sb.push_back(e);
            p = p * 10;
        end
    endtask

    task automatic apply_stimulus(input logic [19:0] val);
        data     = val;
        data_vld = 1'b1;
        @(negedge sys_clk);
        data_vld = 1'b0;
    endtask

    // Each queued digit is checked at the first and last cycle of its dwell window
    task automatic check_output();
        exp_t e;
        int   n;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n = 0;
            while (!(cyc >= 1 && (cyc - 1) % DWELL == 0 && ((cyc - 1) / DWELL) % 6 == e.k)
                   && n < 100) begin
                @(negedge sys_clk);
                n++;
            end
            check_val($sformatf("window_d%0d", e.k), {7'd0, n < 100}, 8'd1);
            check_val($sformatf("sel_first_d%0d", e.k), {2'b00, sel}, {2'b00, e.sel});
            check_val($sformatf("seg_first_d%0d", e.k), seg, e.seg);
            repeat (DWELL - 1) @(negedge sys_clk);
            check_val($sformatf("sel_last_d%0d", e.k), {2'b00, sel}, {2'b00, e.sel});
            check_val($sformatf("seg_last_d%0d", e.k), seg, e.seg);
            @(negedge sys_clk);
        end
    endtask

    task automatic check_busy_run(input int from, input int upto);
        for (int i = from; i <= upto; i++) begin
            check_val($sformatf("busy_N+%0d", i), {7'd0, busy}, {7'd0, (i <= 21)});
            @(negedge sys_clk);
        end
    endtask

    initial begin
        $display("[TB] start, CNT_MAX=%0d", CNT_MAX);
        repeat (3) @(negedge sys_clk);
        check_val("rst_sel", {2'b00, sel}, 8'h3F);
        check_val("rst_seg", seg, 8'hFF);
        check_val("rst_busy", {7'd0, busy}, 8'd0);
        rst = 1'b0;

        $display("[TB] display after reset");
        push_value(0, 6'b0);
        check_output();

        $display("[TB] convert 123456");
        check_val("busy_N", {7'd0, busy}, 8'd0);
        apply_stimulus(20'd123_456);
        check_busy_run(1, 22);
        push_value(123_456, 6'b0);
        check_output();

        $display("[TB] clamp and decimal point");
        apply_stimulus(20'd1_000_000);
        repeat (25) @(negedge sys_clk);
        push_value(1_000_000, 6'b0);
        check_output();
        point = 6'b000100;
        push_value(1_000_000, 6'b000100);
        check_output();
        point = 6'b0;

        $display("[TB] data_vld ignored while busy");
        apply_stimulus(20'd42);
        repeat (4) @(negedge sys_clk);
        apply_stimulus(20'd555_555);
        check_busy_run(6, 22);
        push_value(42, 6'b0);
        check_output();

        $display("[TB] reset mid-conversion");
        apply_stimulus(20'd777_777);
        repeat (9) @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        check_val("midrst_busy", {7'd0, busy}, 8'd0);
        check_val("midrst_sel", {2'b00, sel}, 8'h3F);
        check_val("midrst_seg", seg, 8'hFF);
        rst = 1'b0;
        push_value(0, 6'b0);
        check_output();
        apply_stimulus(20'd987_654);
        check_busy_run(1, 22);

        $display("[TB] display disabled");
        seg_en = 1'b0;
        @(negedge sys_clk);
        for (int i = 0; i < 3; i++) begin
            repeat (7) @(negedge sys_clk);
            check_val("off_sel", {2'b00, sel}, 8'h3F);
            check_val("off_seg", seg, 8'hFF);
        end
        seg_en = 1'b1;
        push_value(987_654, 6'b0);
        check_output();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop if the directed sequence ever stalls
    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
